// File: rtl/dadda_mac_pkg.sv
// Shared widths and helpers for the Dadda multiply-accumulate stage.
package dadda_mac_pkg;

    localparam int unsigned DADDA_N     = 16;
    localparam int unsigned MAC_ACC_W   = 40;
    localparam int unsigned MAC_TERMS_W = 16;

    function automatic logic [MAC_TERMS_W-1:0] sat_inc(input logic [MAC_TERMS_W-1:0] t);
        return (&t) ? t : t + 1'b1;
    endfunction

endpackage

// File: rtl/dadda_mac_dadda.sv
// Combinational unsigned N x N multiplier (the existing Dadda block), Mul = A * B.
module Dadda #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Mul
);

    logic [2*N-1:0] pp_sum;

    always_comb begin
        pp_sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (B[i]) begin
                pp_sum = pp_sum + ({{N{1'b0}}, A} << i);
            end
        end
        Mul = pp_sum;
    end

endmodule

// File: rtl/dadda_mac.sv
// Two-stage multiply-accumulate: S1 registers operands into Dadda, S2 accumulates
// products per group and hands the group sum out over a valid/ready port.
module dadda_mac
    import dadda_mac_pkg::*;
#(
    parameter int unsigned N     = DADDA_N,
    parameter int unsigned ACC_W = MAC_ACC_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_acc,
    output logic [MAC_TERMS_W-1:0] out_terms,
    output logic                   out_ovf
);

    logic [N-1:0]           a_q, a_d, b_q, b_d;
    logic                   last_q, last_d, v1_q, v1_d;
    logic                   first_q, first_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [MAC_TERMS_W-1:0] terms_q, terms_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_W-1:0]       res_acc_q, res_acc_d;
    logic [MAC_TERMS_W-1:0] res_terms_q, res_terms_d;
    logic                   res_ovf_q, res_ovf_d;
    logic                   res_valid_q, res_valid_d;

    logic [2*N-1:0]         prod;
    logic [ACC_W:0]         sum;
    logic [MAC_TERMS_W-1:0] terms_nxt;
    logic                   ovf_nxt;
    logic                   stall, s2_fire, s1_load;

    Dadda #(.N(N)) u_dadda (
        .A   (a_q),
        .B   (b_q),
        .Mul (prod)
    );

    // Only a last term with a result still unclaimed blocks S2.
    assign stall    = v1_q && last_q && res_valid_q && !out_ready;
    assign in_ready = !v1_q || !stall;
    assign s1_load  = in_valid && in_ready;
    assign s2_fire  = v1_q && !stall;

    assign out_valid = res_valid_q;
    assign out_acc   = res_acc_q;
    assign out_terms = res_terms_q;
    assign out_ovf   = res_ovf_q;

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        last_d      = last_q;
        v1_d        = v1_q;
        first_d     = first_q;
        acc_d       = acc_q;
        terms_d     = terms_q;
        ovf_d       = ovf_q;
        res_acc_d   = res_acc_q;
        res_terms_d = res_terms_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q && !out_ready;

        sum       = {1'b0, (first_q ? {ACC_W{1'b0}} : acc_q)} + (ACC_W+1)'(prod);
        ovf_nxt   = first_q ? sum[ACC_W] : (ovf_q | sum[ACC_W]);
        terms_nxt = first_q ? MAC_TERMS_W'(1) : sat_inc(terms_q);

        if (s1_load) begin
            a_d    = in_a;
            b_d    = in_b;
            last_d = in_last;
            v1_d   = 1'b1;
        end else if (s2_fire) begin
            v1_d = 1'b0;
        end

        if (s2_fire) begin
            if (last_q) begin
                res_acc_d   = sum[ACC_W-1:0];
                res_terms_d = terms_nxt;
                res_ovf_d   = ovf_nxt;
                res_valid_d = 1'b1;
                first_d     = 1'b1;
            end else begin
                acc_d   = sum[ACC_W-1:0];
                terms_d = terms_nxt;
                ovf_d   = ovf_nxt;
                first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            last_q      <= 1'b0;
            v1_q        <= 1'b0;
            first_q     <= 1'b1;
            acc_q       <= '0;
            terms_q     <= '0;
            ovf_q       <= 1'b0;
            res_acc_q   <= '0;
            res_terms_q <= '0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            last_q      <= last_d;
            v1_q        <= v1_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            terms_q     <= terms_d;
            ovf_q       <= ovf_d;
            res_acc_q   <= res_acc_d;
            res_terms_q <= res_terms_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_dadda_mac.sv
// Directed and short randomised bench for dadda_mac at ACC_W=40 and ACC_W=33.
module tb_dadda_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_a, in_b;
    logic        in_last;
    logic        out_ready;
    logic        in_ready, in_ready33;
    logic        out_valid, out_valid33;
    logic [39:0] out_acc;
    logic [32:0] out_acc33;
    logic [15:0] out_terms, out_terms33;
    logic        out_ovf, out_ovf33;

    logic ordy, rnd_mode, rnd_rdy;
    assign out_ready = rnd_mode ? rnd_rdy : ordy;

    always #5 clk = ~clk;

    dadda_mac u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_terms(out_terms), .out_ovf(out_ovf)
    );

    dadda_mac #(.ACC_W(33)) u_dut33 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready33),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid33),
        .out_ready(out_ready), .out_acc(out_acc33), .out_terms(out_terms33), .out_ovf(out_ovf33)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] acc;
        logic [15:0] terms;
        logic        ovf;
    } exp_t;

    exp_t        q40[$];
    exp_t        q33[$];
    logic [63:0] m_sum;
    int unsigned m_cnt;
    int unsigned max_wait;

    // Group sums stay far below 2^64, so carry beyond ACC_W is just sum >= 2^ACC_W.
    task automatic push_group();
        exp_t e;
        e.terms = (m_cnt > 16'hFFFF) ? 16'hFFFF : m_cnt[15:0];
        e.acc   = m_sum & ((64'd1 << 40) - 1);
        e.ovf   = (m_sum >= (64'd1 << 40));
        q40.push_back(e);
        e.acc   = m_sum & ((64'd1 << 33) - 1);
        e.ovf   = (m_sum >= (64'd1 << 33));
        q33.push_back(e);
        m_sum = '0;
        m_cnt = 0;
    endtask

    task automatic send_term(input logic [15:0] a, input logic [15:0] b, input logic last);
        bit done = 1'b0;
        int unsigned k;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (k = 0; k < 200 && !done; k++) begin
            #1;
            if (in_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            if (k - 1 > max_wait) max_wait = k - 1;
            @(posedge clk);
            m_sum = m_sum + 64'(a) * 64'(b);
            m_cnt++;
            if (last) push_group();
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 1000 && (q40.size() != 0 || q33.size() != 0); k++) @(negedge clk);
        chk("drain_left", 64'(q40.size() + q33.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rnd_mode) rnd_rdy = 1'($urandom_range(0, 1));
    end

    // Scoreboard plus hold-stability check while backpressured.
    logic        hold_v = 1'b0;
    logic [39:0] held_acc;
    logic [15:0] held_terms;
    logic        held_ovf;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_acc", 64'(out_acc), 64'(held_acc));
                chk("hold_terms", 64'(out_terms), 64'(held_terms));
                chk("hold_ovf", 64'(out_ovf), 64'(held_ovf));
            end
            hold_v     = out_valid && !out_ready;
            held_acc   = out_acc;
            held_terms = out_terms;
            held_ovf   = out_ovf;
            if (out_valid && out_ready) begin
                if (q40.size() == 0) chk("spurious40", 64'd1, 64'd0);
                else begin
                    e = q40.pop_front();
                    chk("sb40_acc", 64'(out_acc), e.acc);
                    chk("sb40_terms", 64'(out_terms), 64'(e.terms));
                    chk("sb40_ovf", 64'(out_ovf), 64'(e.ovf));
                end
            end
            if (out_valid33 && out_ready) begin
                if (q33.size() == 0) chk("spurious33", 64'd1, 64'd0);
                else begin
                    e = q33.pop_front();
                    chk("sb33_acc", 64'(out_acc33), e.acc);
                    chk("sb33_terms", 64'(out_terms33), 64'(e.terms));
                    chk("sb33_ovf", 64'(out_ovf33), 64'(e.ovf));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        ordy = 1'b1; rnd_mode = 1'b0; rnd_rdy = 1'b0;
        m_sum = '0; m_cnt = 0; max_wait = 0;

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_acc", 64'(out_acc), 64'd0);
        chk("rst_out_terms", 64'(out_terms), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single term, latency two edges
        send_term(16'd3, 16'd5, 1'b1);
        chk("single_early_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_acc", 64'(out_acc), 64'd15);
        chk("single_terms", 64'(out_terms), 64'd1);
        chk("single_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk); #1;
        chk("single_valid_drop", 64'(out_valid), 64'd0);

        // max operands, then wrap and a fresh group, all back-to-back
        max_wait = 0;
        repeat (3) send_term(16'hFFFF, 16'hFFFF, 1'b0);
        send_term(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (2) send_term(16'hFFFF, 16'hFFFF, 1'b0);
        send_term(16'hFFFF, 16'hFFFF, 1'b1);
        chk("max_acc", 64'(out_acc), 64'h3_FFF8_0004);
        chk("max_terms", 64'(out_terms), 64'd4);
        chk("max_ovf", 64'(out_ovf), 64'd0);
        chk("max33_acc", 64'(out_acc33), 64'h1_FFF8_0004);
        chk("max33_ovf", 64'(out_ovf33), 64'd1);
        send_term(16'd2, 16'd3, 1'b1);
        chk("wrap40_acc", 64'(out_acc), 64'h2_FFFA_0003);
        chk("wrap33_acc", 64'(out_acc33), 64'h0_FFFA_0003);
        chk("wrap33_terms", 64'(out_terms33), 64'd3);
        chk("wrap33_ovf", 64'(out_ovf33), 64'd1);
        chk("b2b_no_stall", 64'(max_wait), 64'd0);
        @(posedge clk); #1;
        chk("after_wrap33_acc", 64'(out_acc33), 64'd6);
        chk("after_wrap33_ovf", 64'(out_ovf33), 64'd0);
        chk("after_wrap40_terms", 64'(out_terms), 64'd1);
        wait_drain();

        // backpressure
        @(negedge clk); ordy = 1'b0;
        send_term(16'd2, 16'd2, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        chk("bp_held_acc", 64'(out_acc), 64'd4);
        send_term(16'd1, 16'd1, 1'b0);
        send_term(16'd1, 16'd7, 1'b1);
        chk("bp_stall_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_stall_ready2", 64'(in_ready), 64'd0);
        chk("bp_still_acc", 64'(out_acc), 64'd4);
        @(negedge clk); ordy = 1'b1; #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_pop_acc", 64'(out_acc), 64'd4);
        @(posedge clk); #1;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_acc", 64'(out_acc), 64'd8);
        chk("bp_next_terms", 64'(out_terms), 64'd2);
        wait_drain();

        // reset mid-group
        send_term(16'd10, 16'd10, 1'b0);
        send_term(16'd10, 16'd10, 1'b0);
        @(negedge clk); #3;
        rst_n = 1'b0; #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_acc", 64'(out_acc), 64'd0);
        chk("mid_rst_terms", 64'(out_terms), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        m_sum = '0; m_cnt = 0;
        q40.delete(); q33.delete();
        @(negedge clk); rst_n = 1'b1;
        send_term(16'd6, 16'd7, 1'b1);
        @(posedge clk); #1;
        chk("post_rst_acc", 64'(out_acc), 64'd42);
        chk("post_rst_terms", 64'(out_terms), 64'd1);
        wait_drain();

        // random groups with input gaps and random out_ready
        rnd_mode = 1'b1;
        for (int g = 0; g < 150; g++) begin
            int unsigned nt = $urandom_range(1, 10);
            for (int t = 0; t < nt; t++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_term(16'($urandom), 16'($urandom), (t == nt - 1));
            end
        end
        rnd_mode = 1'b0;
        ordy = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
